// File: rtl/alu_pipe_nstage_hs.sv
// Three-stage handshaked ALU pipeline: S1 operand latch, S2 execute, S3 result register.
// Optional result register file enabled by defining ALU_RESULT_RF_EN.
module alu_pipe_nstage_hs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [ADDR_W-1:0] out_addr,
    output logic [2:0]        out_flags,
`ifdef ALU_RESULT_RF_EN
    input  logic [ADDR_W-1:0] rf_raddr,
    output logic [DATA_W-1:0] rf_rdata,
`endif
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    logic              s1_v, s2_v, s3_v;
    logic              s1_en, s2_en, s3_en;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [2:0]        s1_op;
    logic [ADDR_W-1:0] s1_addr, s2_addr;
    logic [DATA_W-1:0] s2_result;
    logic [2:0]        s2_flags;

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum_ext;
    logic              is_sub, is_arith, add_ovf, slt_bit;
    logic [DATA_W-1:0] alu_result;
    logic [2:0]        alu_flags;

    // Enables only look at registered valids and out_ready, so no comb path from in_valid.
    assign s3_en     = !s3_v || out_ready;
    assign s2_en     = !s2_v || s3_en;
    assign s1_en     = !s1_v || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s3_v;

    always_comb begin
        is_sub   = (s1_op == OP_SUB);
        is_arith = (s1_op == OP_ADD) || is_sub;
        b_eff    = is_sub ? ~s1_b : s1_b;
        sum_ext  = {1'b0, s1_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
        add_ovf  = (s1_a[DATA_W-1] == b_eff[DATA_W-1]) && (sum_ext[DATA_W-1] != s1_a[DATA_W-1]);
        slt_bit  = ($signed(s1_a) < $signed(s1_b));
        alu_result = '0;
        case (s1_op)
            OP_AND:  alu_result = s1_a & s1_b;
            OP_OR:   alu_result = s1_a | s1_b;
            OP_XOR:  alu_result = s1_a ^ s1_b;
            OP_ADD:  alu_result = sum_ext[DATA_W-1:0];
            OP_SUB:  alu_result = sum_ext[DATA_W-1:0];
            OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, slt_bit};
            OP_SLL:  alu_result = s1_a << s1_b[SH_W-1:0];
            OP_SRL:  alu_result = s1_a >> s1_b[SH_W-1:0];
            default: alu_result = '0;
        endcase
        alu_flags = {is_arith && add_ovf, is_arith && sum_ext[DATA_W], alu_result == '0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s3_v       <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= '0;
            s1_addr    <= '0;
            s2_result  <= '0;
            s2_flags   <= '0;
            s2_addr    <= '0;
            out_result <= '0;
            out_flags  <= '0;
            out_addr   <= '0;
            done_cnt   <= '0;
        end else begin
            if (s1_en) begin
                s1_v    <= in_valid;
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_op   <= in_op;
                s1_addr <= in_addr;
            end
            if (s2_en) begin
                s2_v      <= s1_v;
                s2_result <= alu_result;
                s2_flags  <= alu_flags;
                s2_addr   <= s1_addr;
            end
            if (s3_en) begin
                s3_v       <= s2_v;
                out_result <= s2_result;
                out_flags  <= s2_flags;
                out_addr   <= s2_addr;
            end
            if (s3_v && out_ready)
                done_cnt <= done_cnt + 1'b1;
        end
    end

`ifdef ALU_RESULT_RF_EN
    logic [DATA_W-1:0] rf_mem [2**ADDR_W];

    // Storage is intentionally not reset; a read of the written address returns the old word.
    always_ff @(posedge clk) begin
        if (!rst && s3_v && out_ready)
            rf_mem[out_addr] <= out_result;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rf_rdata <= '0;
        else
            rf_rdata <= rf_mem[rf_raddr];
    end
`endif

endmodule
